// File: rtl/vga_mem_arbiter.sv
// Single-port pixel memory arbiter: VGA scanout reads have priority, the CPU
// req/ack port is served in gaps, and a wait counter forces a CPU grant.
module vga_mem_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_VGA    = 2'd1,
        SRC_CPU_RD = 2'd2
    } src_e;

    // CPU handshake: cpu_req is a level held with stable we/addr/wdata until
    // cpu_ack pulses for one cycle; the request is not re-sampled before the
    // cycle after that pulse, so a held req starts a new transaction there.

    src_e              tag1_q, tag1_d;
    src_e              tag2_q, tag2_d;
    logic              cpu_busy_q, cpu_busy_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              wr_ack_q, wr_ack_d;
    logic              vga_miss_q, vga_miss_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic cpu_elig;
    logic force_cpu;
    logic grant_cpu;
    logic grant_vga;

    assign vga_valid = (tag2_q == SRC_VGA);
    assign cpu_ack   = (tag2_q == SRC_CPU_RD) || wr_ack_q;
    assign vga_miss  = vga_miss_q;
    assign vga_data  = vga_data_q;
    assign cpu_rdata = cpu_rdata_q;

    always_comb begin
        cpu_elig  = cpu_req && !cpu_busy_q && !cpu_ack;
        force_cpu = cpu_elig && (wait_cnt_q == MAX_WAIT_C);
        grant_cpu = !reset && (force_cpu || (cpu_elig && !vga_req));
        grant_vga = !reset && vga_req && !force_cpu;

        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (grant_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (grant_vga) begin
            mem_addr = vga_addr;
        end
    end

    always_comb begin
        tag1_d      = SRC_NONE;
        tag2_d      = tag1_q;
        cpu_busy_d  = cpu_busy_q;
        wait_cnt_d  = wait_cnt_q;
        wr_ack_d    = grant_cpu && cpu_we;
        vga_miss_d  = force_cpu && vga_req;
        vga_data_d  = vga_data_q;
        cpu_rdata_d = cpu_rdata_q;

        if (grant_vga) begin
            tag1_d = SRC_VGA;
        end else if (grant_cpu && !cpu_we) begin
            tag1_d = SRC_CPU_RD;
        end

        // Read data arrives the cycle after the address; tag stage 1 routes it.
        if (tag1_q == SRC_VGA) begin
            vga_data_d = mem_rdata;
        end
        if (tag1_q == SRC_CPU_RD) begin
            cpu_rdata_d = mem_rdata;
        end

        if (grant_cpu) begin
            cpu_busy_d = 1'b1;
        end else if (cpu_ack) begin
            cpu_busy_d = 1'b0;
        end

        if (grant_cpu || !cpu_req) begin
            wait_cnt_d = 8'd0;
        end else if (cpu_elig && (wait_cnt_q != MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag1_q      <= SRC_NONE;
            tag2_q      <= SRC_NONE;
            cpu_busy_q  <= 1'b0;
            wait_cnt_q  <= 8'd0;
            wr_ack_q    <= 1'b0;
            vga_miss_q  <= 1'b0;
            vga_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            cpu_busy_q  <= cpu_busy_d;
            wait_cnt_q  <= wait_cnt_d;
            wr_ack_q    <= wr_ack_d;
            vga_miss_q  <= vga_miss_d;
            vga_data_q  <= vga_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Randomized bench for vga_mem_arbiter with a transaction-level model that
// schedules expected outputs per cycle from the grant priority rules.
module tb_vga_mem_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int MW   = 8;
    localparam int NCYC = 3000;

    logic          clock = 1'b0;
    logic          reset;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic          vga_miss;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    always #5 clock = ~clock;

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clock     (clock),
        .reset     (reset),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .vga_miss  (vga_miss),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Synchronous-read pixel RAM behind the arbiter.
    logic [DW-1:0] ram [16];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Expected-output schedule, indexed by cycle.
    bit            ev_valid [NCYC+4];
    logic [DW-1:0] ev_data  [NCYC+4];
    bit            ec_ack   [NCYC+4];
    bit            ec_rd    [NCYC+4];
    logic [DW-1:0] ec_data  [NCYC+4];
    bit            em_miss  [NCYC+4];
    bit            er_reset [NCYC+4];

    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_vga_data;
    logic [DW-1:0] exp_cpu_rdata;
    int            m_ack_cycle;
    int            m_wait;

    initial begin
        int            pend;
        int            mode;
        logic [AW-1:0] seq_addr;
        bit            elig, force_cpu, g_cpu, g_vga, done, start;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wdata;
        logic          x_we;

        reset     = 1'b1;
        vga_req   = 1'b0;
        vga_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = DW'(i * 16);
            ref_mem[i] = DW'(i * 16);
        end
        for (int i = 0; i < NCYC + 4; i++) begin
            ev_valid[i] = 0; ev_data[i] = '0; ec_ack[i] = 0; ec_rd[i] = 0;
            ec_data[i] = '0; em_miss[i] = 0; er_reset[i] = 0;
        end
        exp_vga_data  = '0;
        exp_cpu_rdata = '0;
        m_ack_cycle   = -1;
        m_wait        = 0;
        pend          = 0;
        seq_addr      = '0;

        @(negedge clock);
        er_reset[0] = 1;
        for (cyc = 0; cyc < NCYC; cyc++) begin
            // Registered outputs for this cycle.
            if (er_reset[cyc]) begin
                exp_vga_data  = '0;
                exp_cpu_rdata = '0;
            end
            if (ev_valid[cyc]) exp_vga_data = ev_data[cyc];
            if (ec_rd[cyc]) exp_cpu_rdata = ec_data[cyc];
            check_eq("vga_valid", 32'(vga_valid), 32'(ev_valid[cyc]));
            check_eq("vga_data", 32'(vga_data), 32'(exp_vga_data));
            check_eq("vga_miss", 32'(vga_miss), 32'(em_miss[cyc]));
            check_eq("cpu_ack", 32'(cpu_ack), 32'(ec_ack[cyc]));
            check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));

            // Stimulus phases: reset, VGA burst, CPU only, mixed, VGA every
            // other cycle with reads, continuous VGA with writes, random resets.
            if (cyc < 4)         mode = 0;
            else if (cyc < 36)   mode = 1;
            else if (cyc < 200)  mode = 2;
            else if (cyc < 700)  mode = 3;
            else if (cyc < 1200) mode = 4;
            else if (cyc < 1700) mode = 5;
            else if (cyc < 2500) mode = 6;
            else                 mode = 3;

            reset = (mode == 0) || (mode == 6 && $urandom_range(0, 24) == 0);
            case (mode)
                1:       begin vga_req = 1'b1; vga_addr = seq_addr; seq_addr = seq_addr + 1'b1; end
                2:       begin vga_req = 1'b0; vga_addr = AW'($urandom_range(0, 15)); end
                4:       begin vga_req = cyc[0]; vga_addr = AW'($urandom_range(0, 15)); end
                5:       begin vga_req = 1'b1; vga_addr = AW'($urandom_range(0, 15)); end
                default: begin vga_req = 1'($urandom_range(0, 1)); vga_addr = AW'($urandom_range(0, 15)); end
            endcase

            // CPU driver: hold req until ack, then maybe issue back-to-back.
            done = cpu_req && cpu_ack;
            if (cpu_req && !done) begin
                pend++;
                if (pend > 40) begin
                    check_eq("cpu_wait_bound", 32'(pend), 32'd40);
                    cpu_req = 1'b0;
                    pend    = 0;
                end
            end else begin
                case (mode)
                    0, 1:    start = 0;
                    4, 5:    start = 1;
                    default: start = ($urandom_range(0, 2) != 0);
                endcase
                pend = 0;
                if (start) begin
                    cpu_req   = 1'b1;
                    cpu_we    = (mode == 4) ? 1'b0 : (mode == 5) ? 1'b1 : 1'($urandom_range(0, 1));
                    cpu_addr  = AW'($urandom_range(0, 15));
                    cpu_wdata = DW'($urandom_range(0, 255));
                end else begin
                    cpu_req = 1'b0;
                end
            end

            #1;
            // Reference model of the grant for this cycle.
            x_addr  = '0;
            x_we    = 1'b0;
            x_wdata = '0;
            if (reset) begin
                ev_valid[cyc+1] = 0; ec_ack[cyc+1] = 0; ec_rd[cyc+1] = 0;
                em_miss[cyc+1]  = 0; er_reset[cyc+1] = 1;
                m_ack_cycle = -1;
                m_wait      = 0;
            end else begin
                elig      = cpu_req && (cyc > m_ack_cycle);
                force_cpu = elig && (m_wait == MW);
                g_cpu     = force_cpu || (elig && !vga_req);
                g_vga     = vga_req && !force_cpu;
                if (force_cpu && vga_req) em_miss[cyc+1] = 1;
                if (g_vga) begin
                    ev_valid[cyc+2] = 1;
                    ev_data[cyc+2]  = ref_mem[vga_addr];
                    x_addr          = vga_addr;
                end
                if (g_cpu) begin
                    x_addr = cpu_addr;
                    if (cpu_we) begin
                        x_we              = 1'b1;
                        x_wdata           = cpu_wdata;
                        ref_mem[cpu_addr] = cpu_wdata;
                        ec_ack[cyc+1]     = 1;
                        m_ack_cycle       = cyc + 1;
                    end else begin
                        ec_ack[cyc+2]  = 1;
                        ec_rd[cyc+2]   = 1;
                        ec_data[cyc+2] = ref_mem[cpu_addr];
                        m_ack_cycle    = cyc + 2;
                    end
                end
                if (g_cpu || !cpu_req) m_wait = 0;
                else if (elig && m_wait < MW) m_wait = m_wait + 1;
            end
            check_eq("mem_we", 32'(mem_we), 32'(x_we));
            check_eq("mem_addr", 32'(mem_addr), 32'(x_addr));
            if (x_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(x_wdata));

            @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
